// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between the column and row result FIFOs.
// Each grant sends a source header byte, then up to BURST data bytes from that source.
module uart_tx_arbiter #(
    parameter int unsigned          W_DATA  = 8,
    parameter int unsigned          BURST   = 16,
    parameter logic [W_DATA-1:0]    HDR_COL = 8'hC0,
    parameter logic [W_DATA-1:0]    HDR_ROW = 8'hA0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_col_valid,
    input  logic [W_DATA-1:0] i_col_data,
    output logic              o_col_ready,
    input  logic              i_row_valid,
    input  logic [W_DATA-1:0] i_row_data,
    output logic              o_row_ready,
    output logic              o_tx_dv,
    output logic [W_DATA-1:0] o_tx_byte,
    input  logic              i_tx_active,
    input  logic              i_tx_done,
    output logic [1:0]        o_grant,
    output logic              o_busy
);

    localparam logic [7:0] BurstMax = 8'(BURST);

    typedef enum logic [1:0] {
        StIdle,
        StHdrWait,
        StData,
        StDataWait
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        count_q, count_d;
    logic              last_row_q, last_row_d;
    logic [1:0]        grant_q, grant_d;
    logic              tx_dv_q, tx_dv_d;
    logic [W_DATA-1:0] tx_byte_q, tx_byte_d;
    logic              col_ready_q, col_ready_d;
    logic              row_ready_q, row_ready_d;
    logic              busy_q, busy_d;

    logic              pick_row;
    logic              granted_valid;
    logic [W_DATA-1:0] granted_data;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        last_row_d  = last_row_q;
        grant_d     = grant_q;
        tx_dv_d     = 1'b0;
        tx_byte_d   = tx_byte_q;
        col_ready_d = 1'b0;
        row_ready_d = 1'b0;
        pick_row    = 1'b0;

        granted_valid = grant_q[0] ? i_col_valid : i_row_valid;
        granted_data  = grant_q[0] ? i_col_data  : i_row_data;

        unique case (state_q)
            StIdle: begin
                if (!i_tx_active && (i_col_valid || i_row_valid)) begin
                    // On a tie the source that was not served last wins.
                    pick_row  = i_row_valid && (!i_col_valid || !last_row_q);
                    grant_d   = pick_row ? 2'b10 : 2'b01;
                    tx_dv_d   = 1'b1;
                    tx_byte_d = pick_row ? HDR_ROW : HDR_COL;
                    count_d   = 8'd0;
                    state_d   = StHdrWait;
                end
            end
            StHdrWait: begin
                if (i_tx_done) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (granted_valid && (count_q < BurstMax)) begin
                    tx_dv_d     = 1'b1;
                    tx_byte_d   = granted_data;
                    col_ready_d = grant_q[0];
                    row_ready_d = grant_q[1];
                    count_d     = count_q + 8'd1;
                    state_d     = StDataWait;
                end else begin
                    last_row_d = grant_q[1];
                    grant_d    = 2'b00;
                    state_d    = StIdle;
                end
            end
            StDataWait: begin
                if (i_tx_done) begin
                    state_d = StData;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            count_q     <= 8'd0;
            // Reset as if the row was served last so the column wins the first tie.
            last_row_q  <= 1'b1;
            grant_q     <= 2'b00;
            tx_dv_q     <= 1'b0;
            tx_byte_q   <= '0;
            col_ready_q <= 1'b0;
            row_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            last_row_q  <= last_row_d;
            grant_q     <= grant_d;
            tx_dv_q     <= tx_dv_d;
            tx_byte_q   <= tx_byte_d;
            col_ready_q <= col_ready_d;
            row_ready_q <= row_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign o_tx_dv     = tx_dv_q;
    assign o_tx_byte   = tx_byte_q;
    assign o_col_ready = col_ready_q;
    assign o_row_ready = row_ready_q;
    assign o_grant     = grant_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: FWFT source queues, a behavioural uart_tx, and a
// packet-level reference model of the round-robin header/burst stream.
module tb_uart_tx_arbiter;

    localparam int unsigned BURST   = 4;
    localparam logic [7:0]  HDR_COL = 8'hC0;
    localparam logic [7:0]  HDR_ROW = 8'hA0;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_col_valid, i_row_valid;
    logic [7:0] i_col_data, i_row_data;
    logic       o_col_ready, o_row_ready;
    logic       o_tx_dv;
    logic [7:0] o_tx_byte;
    logic       i_tx_active, i_tx_done;
    logic [1:0] o_grant;
    logic       o_busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .W_DATA (8),
        .BURST  (BURST),
        .HDR_COL(HDR_COL),
        .HDR_ROW(HDR_ROW)
    ) u_dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_col_valid(i_col_valid),
        .i_col_data (i_col_data),
        .o_col_ready(o_col_ready),
        .i_row_valid(i_row_valid),
        .i_row_data (i_row_data),
        .o_row_ready(o_row_ready),
        .o_tx_dv    (o_tx_dv),
        .o_tx_byte  (o_tx_byte),
        .i_tx_active(i_tx_active),
        .i_tx_done  (i_tx_done),
        .o_grant    (o_grant),
        .o_busy     (o_busy)
    );

    typedef struct {
        int n_col;
        int n_row;
        int exp_hdrs;
        int exp_col_pops;
        int exp_row_pops;
    } vec_t;

    logic [7:0] col_q[$];
    logic [7:0] row_q[$];
    logic [7:0] mc_q[$];
    logic [7:0] mr_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] tx_log[$];
    logic [7:0] pop_tmp;
    logic       col_hold, row_hold;
    int         checks = 0;
    int         errors = 0;
    int         hdr_cnt, col_pops, row_pops;
    int         uart_cnt, frame_fixed;
    int         model_last;  // 0: column served last, 1: row served last
    vec_t       vecs[6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    task automatic drive_src();
        i_col_valid = (col_q.size() != 0) && !col_hold;
        i_col_data  = (col_q.size() != 0) ? col_q[0] : 8'h00;
        i_row_valid = (row_q.size() != 0) && !row_hold;
        i_row_data  = (row_q.size() != 0) ? row_q[0] : 8'h00;
    endtask

    // FWFT sources and behavioural uart_tx, all acting mid-cycle.
    always @(negedge clk) begin
        if (o_tx_dv) begin
            check("no_dv_while_active", int'(i_tx_active), 0);
            if (o_col_ready || o_row_ready) begin
                check("ready_matches_grant", int'({o_row_ready, o_col_ready}), int'(o_grant));
                if (o_col_ready) begin
                    if (col_q.size() == 0) fail_now("col_pop_of_empty");
                    else begin
                        check("col_pop_byte", int'(o_tx_byte), int'(col_q[0]));
                        pop_tmp = col_q.pop_front();
                        col_pops++;
                    end
                end
                if (o_row_ready) begin
                    if (row_q.size() == 0) fail_now("row_pop_of_empty");
                    else begin
                        check("row_pop_byte", int'(o_tx_byte), int'(row_q[0]));
                        pop_tmp = row_q.pop_front();
                        row_pops++;
                    end
                end
            end else begin
                check("hdr_grant_onehot", int'(o_grant == 2'b01 || o_grant == 2'b10), 1);
                hdr_cnt++;
            end
            tx_log.push_back(o_tx_byte);
        end else if (o_col_ready || o_row_ready) begin
            fail_now("ready_without_dv");
        end

        if (i_tx_done) i_tx_done = 1'b0;
        if (i_tx_active) begin
            uart_cnt--;
            if (uart_cnt <= 0) begin
                i_tx_active = 1'b0;
                i_tx_done   = 1'b1;
            end
        end
        if (o_tx_dv) begin
            i_tx_active = 1'b1;
            uart_cnt    = (frame_fixed != 0) ? frame_fixed : int'($urandom_range(2, 6));
        end
        drive_src();
    end

    // Packet-level model: pick a source by round-robin, header, then up to BURST bytes.
    task automatic model_run();
        int take_row;
        int n;
        exp_q.delete();
        while (mc_q.size() != 0 || mr_q.size() != 0) begin
            if (mc_q.size() == 0)      take_row = 1;
            else if (mr_q.size() == 0) take_row = 0;
            else                       take_row = (model_last == 0) ? 1 : 0;
            exp_q.push_back(take_row ? HDR_ROW : HDR_COL);
            n = 0;
            while (n < int'(BURST) && (take_row ? mr_q.size() : mc_q.size()) != 0) begin
                if (take_row) exp_q.push_back(mr_q.pop_front());
                else          exp_q.push_back(mc_q.pop_front());
                n++;
            end
            model_last = take_row;
        end
    endtask

    task automatic clear_log();
        tx_log.delete();
        hdr_cnt  = 0;
        col_pops = 0;
        row_pops = 0;
    endtask

    task automatic load(input int n_col, input int n_row, input bit rnd);
        for (int i = 0; i < n_col; i++)
            col_q.push_back(rnd ? 8'($urandom) : 8'((i + 1) * 17));
        for (int i = 0; i < n_row; i++)
            row_q.push_back(rnd ? 8'($urandom) : 8'(8'h50 + i));
        mc_q = col_q;
        mr_q = row_q;
        drive_src();
    endtask

    task automatic wait_idle(input string name);
        int stable = 0;
        int n = 0;
        while (stable < 4 && n < 4000) begin
            @(negedge clk);
            n++;
            if (!o_busy && !i_tx_active && (col_q.size() == 0 || col_hold)
                && (row_q.size() == 0 || row_hold)) stable++;
            else stable = 0;
        end
        if (stable < 4) fail_now({name, "_idle_timeout"});
    endtask

    task automatic compare_stream(input string name);
        check({name, "_len"}, tx_log.size(), exp_q.size());
        for (int i = 0; i < tx_log.size() && i < exp_q.size(); i++)
            check($sformatf("%s_byte%0d", name, i), int'(tx_log[i]), int'(exp_q[i]));
    endtask

    initial begin
        int nc, nr, n;
        i_rst       = 1'b1;
        i_tx_active = 1'b0;
        i_tx_done   = 1'b0;
        col_hold    = 1'b0;
        row_hold    = 1'b0;
        frame_fixed = 0;
        uart_cnt    = 0;
        model_last  = 1;
        clear_log();
        drive_src();

        vecs[0] = '{n_col: 0,  n_row: 2, exp_hdrs: 1, exp_col_pops: 0,  exp_row_pops: 2};
        vecs[1] = '{n_col: 0,  n_row: 1, exp_hdrs: 1, exp_col_pops: 0,  exp_row_pops: 1};
        vecs[2] = '{n_col: 10, n_row: 0, exp_hdrs: 3, exp_col_pops: 10, exp_row_pops: 0};
        vecs[3] = '{n_col: 8,  n_row: 8, exp_hdrs: 4, exp_col_pops: 8,  exp_row_pops: 8};
        vecs[4] = '{n_col: 6,  n_row: 9, exp_hdrs: 5, exp_col_pops: 6,  exp_row_pops: 9};
        vecs[5] = '{n_col: 4,  n_row: 4, exp_hdrs: 2, exp_col_pops: 4,  exp_row_pops: 4};

        repeat (3) @(negedge clk);
        check("rst_tx_dv", int'(o_tx_dv), 0);
        check("rst_tx_byte", int'(o_tx_byte), 0);
        check("rst_col_ready", int'(o_col_ready), 0);
        check("rst_row_ready", int'(o_row_ready), 0);
        check("rst_grant", int'(o_grant), 0);
        check("rst_busy", int'(o_busy), 0);
        i_rst = 1'b0;
        repeat (2) @(negedge clk);

        // Column only: header one cycle after valid, single-cycle pulse.
        clear_log();
        col_q.push_back(8'h11);
        col_q.push_back(8'h22);
        col_q.push_back(8'h33);
        drive_src();
        @(negedge clk);
        check("hdr_dv_k1", int'(o_tx_dv), 1);
        check("hdr_byte_col", int'(o_tx_byte), int'(HDR_COL));
        check("hdr_grant_col", int'(o_grant), 1);
        check("hdr_busy", int'(o_busy), 1);
        @(negedge clk);
        check("hdr_dv_one_cycle", int'(o_tx_dv), 0);
        wait_idle("col_only");
        exp_q = '{HDR_COL, 8'h11, 8'h22, 8'h33};
        compare_stream("col_only");
        check("col_only_pops", col_pops, 3);
        check("col_only_grant_end", int'(o_grant), 0);
        model_last = 0;

        // Header-only packet: valid drops while the header is on the wire.
        clear_log();
        frame_fixed = 4;
        col_q.push_back(8'h77);
        drive_src();
        n = 0;
        while (hdr_cnt == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        col_hold = 1'b1;
        drive_src();
        wait_idle("hdr_only");
        exp_q = '{HDR_COL};
        compare_stream("hdr_only");
        check("hdr_only_pops", col_pops, 0);
        clear_log();
        col_hold = 1'b0;
        drive_src();
        wait_idle("hdr_only_resume");
        exp_q = '{HDR_COL, 8'h77};
        compare_stream("hdr_only_resume");
        frame_fixed = 0;
        model_last = 0;

        foreach (vecs[v]) begin
            clear_log();
            load(vecs[v].n_col, vecs[v].n_row, 1'b0);
            model_run();
            wait_idle($sformatf("vec%0d", v));
            compare_stream($sformatf("vec%0d", v));
            check($sformatf("vec%0d_hdrs", v), hdr_cnt, vecs[v].exp_hdrs);
            check($sformatf("vec%0d_col_pops", v), col_pops, vecs[v].exp_col_pops);
            check($sformatf("vec%0d_row_pops", v), row_pops, vecs[v].exp_row_pops);
            check($sformatf("vec%0d_grant_end", v), int'(o_grant), 0);
            check($sformatf("vec%0d_busy_end", v), int'(o_busy), 0);
        end

        for (int r = 0; r < 8; r++) begin
            clear_log();
            nc = int'($urandom_range(0, 11));
            nr = int'($urandom_range(0, 11));
            load(nc, nr, 1'b1);
            model_run();
            wait_idle($sformatf("rnd%0d", r));
            compare_stream($sformatf("rnd%0d", r));
            check($sformatf("rnd%0d_col_pops", r), col_pops, nc);
            check($sformatf("rnd%0d_row_pops", r), row_pops, nr);
        end

        // Reset while a data byte is on the wire; its done must be ignored.
        clear_log();
        frame_fixed = 8;
        load(8, 0, 1'b0);
        n = 0;
        while (col_pops < 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (col_pops < 2) fail_now("rst_mid_reach_data");
        i_rst = 1'b1;
        @(negedge clk);
        check("rst_mid_tx_dv", int'(o_tx_dv), 0);
        check("rst_mid_tx_byte", int'(o_tx_byte), 0);
        check("rst_mid_col_ready", int'(o_col_ready), 0);
        check("rst_mid_grant", int'(o_grant), 0);
        check("rst_mid_busy", int'(o_busy), 0);
        check("rst_mid_uart_active", int'(i_tx_active), 1);
        i_rst = 1'b0;
        clear_log();
        n = 0;
        while (i_tx_active && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_no_issue_while_active", tx_log.size(), 0);
        frame_fixed = 0;
        model_last = 1;
        mc_q = col_q;
        mr_q = row_q;
        model_run();
        wait_idle("rst_mid");
        compare_stream("rst_mid");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
